cp0_timer_ext: RTL and testbench

- Parametrised next-generation CP0 for the pipelined MIPS core.
- Adds to the current CP0: a configurable number of hardware interrupt lines, a Count/Compare timer interrupt, a BadVAddr register, and fixed priority between entry, ERET and MTC0.
- Sits at the M stage.
  - Receives MTC0/MFC0 accesses, exception/interrupt causes, PC and the delay-slot flag.
  - Returns the entry request and EPC to the NPC/flush logic.

---
 rtl/cp0_timer_ext.sv | 186 ++++++++++++++++++
 tb/tb_cp0_timer_ext.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_ext.sv
// CP0 coprocessor for the M stage: SR/Cause/EPC/PRId plus a Count/Compare timer,
// BadVAddr capture and a configurable number of level-sensitive hardware interrupts.
module cp0_timer_ext #(
    parameter int          NUM_HWINT = 5,
    parameter int          TIMER_EN  = 1,
    parameter int          COUNT_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h12345678
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    input  logic [31:0]          pc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr_in,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_SR       = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;
    localparam logic [4:0] A_PRID     = 5'd15;

    // IM[15] (timer) is always writable; only the implemented hardware lines below it are.
    localparam logic [5:0] IM_MASK   = {1'b1, 5'((32'd1 << NUM_HWINT) - 32'd1)};
    localparam logic [3:0] PRESC_MAX = 4'((32'd1 << COUNT_DIV) - 32'd1);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [4:0]  ip_hw_q;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [3:0]  presc_q, presc_d;

    logic [4:0]  hw_ext;
    logic [5:0]  ip_live;
    logic        int_req;
    logic        exc_req;
    logic        req_c;
    logic        tick;
    logic [31:0] count_inc;
    logic [31:0] epc_base;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        hw_ext                  = '0;
        hw_ext[NUM_HWINT-1:0]   = hwint;
    end

    // Live (unregistered) interrupt lines so a request is taken in the cycle it appears.
    always_comb begin
        ip_live  = {ti_q, hw_ext};
        int_req  = reset & ie_q & ~exl_q & (|(ip_live & im_q));
        exc_req  = reset & ~exl_q & (exc_code != 5'd0);
        req_c    = int_req | exc_req;
        epc_base = {pc[31:2], 2'b00};
    end

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        tick      = 1'b0;
        count_inc = count_q + 32'd1;
        if (TIMER_EN != 0) begin
            tick = (presc_q == PRESC_MAX);
            if (tick) begin
                presc_d = 4'd0;
                count_d = count_inc;
                if ((count_inc == compare_q) && (compare_q != 32'd0)) begin
                    ti_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + 4'd1;
            end
            // Software writes override the timer's own update in the same cycle.
            if (we && (wr_addr == A_COUNT)) begin
                count_d = din;
                presc_d = 4'd0;
            end
            if (we && (wr_addr == A_COMPARE)) begin
                compare_d = din;
                ti_d      = 1'b0;
            end
        end
    end

    // Applied lowest to highest priority: MTC0, then ERET, then exception entry.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (we && (wr_addr == A_SR)) begin
            im_d  = din[15:10] & IM_MASK;
            exl_d = din[1];
            ie_d  = din[0];
        end
        if (we && (wr_addr == A_EPC)) begin
            epc_d = {din[31:2], 2'b00};
        end
        if (eret && !req_c) begin
            exl_d = 1'b0;
            bd_d  = 1'b0;
        end
        if (req_c) begin
            exl_d      = 1'b1;
            bd_d       = bd_in;
            epc_d      = bd_in ? (epc_base - 32'd4) : epc_base;
            exc_code_d = int_req ? 5'd0 : exc_code;
            if (!int_req && ((exc_code == 5'd4) || (exc_code == 5'd5))) begin
                badvaddr_d = bad_vaddr_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            exc_code_q <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            presc_q    <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            exc_code_q <= exc_code_d;
            ip_hw_q    <= hw_ext;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (rd_addr)
            A_SR:       dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            A_CAUSE:    dout = {bd_q, ti_q, 14'd0, ti_q, ip_hw_q, 3'd0, exc_code_q, 2'b00};
            A_EPC:      dout = epc_q;
            A_PRID:     dout = PRID_VAL;
            A_COUNT:    dout = count_q;
            A_COMPARE:  dout = compare_q;
            A_BADVADDR: dout = badvaddr_q;
            default:    dout = 32'd0;
        endcase
    end

    assign req = req_c;
    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_timer_ext.sv
// Directed bench for cp0_timer_ext: stimulus queues expected register/port values,
// a monitor on the falling edge reads them back and compares.
module tb_cp0_timer_ext;

    localparam int NHW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           we;
    logic [4:0]     rd_addr;
    logic [4:0]     wr_addr;
    logic [31:0]    din;
    logic [31:0]    dout;
    logic [31:0]    pc;
    logic           bd_in;
    logic [4:0]     exc_code;
    logic [31:0]    bad_vaddr_in;
    logic [NHW-1:0] hwint;
    logic           eret;
    logic           req;
    logic [31:0]    epc;

    cp0_timer_ext #(
        .NUM_HWINT(NHW),
        .TIMER_EN (1),
        .COUNT_DIV(1),
        .PRID_VAL (32'h12345678)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .din         (din),
        .dout        (dout),
        .pc          (pc),
        .bd_in       (bd_in),
        .exc_code    (exc_code),
        .bad_vaddr_in(bad_vaddr_in),
        .hwint       (hwint),
        .eret        (eret),
        .req         (req),
        .epc         (epc)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0: dout at addr, 1: req, 2: epc port
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_reg(input string n, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = 0; e.addr = a; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_req(input string n, input logic v);
        exp_t e;
        e.name = n; e.kind = 1; e.addr = 5'd0; e.val = {31'd0, v};
        exp_q.push_back(e);
    endtask

    task automatic exp_epc(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = 2; e.addr = 5'd0; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
        we = 1'b1; wr_addr = a; din = v;
        cyc();
        we = 1'b0;
    endtask

    // Monitor: drains the expectation queue between edges while inputs are stable.
    initial begin
        exp_t        it;
        logic [31:0] got;
        rd_addr = 5'd0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                if (it.kind == 0) rd_addr = it.addr;
                #1;
                case (it.kind)
                    0:       got = dout;
                    1:       got = {31'd0, req};
                    default: got = epc;
                endcase
                n_cmp++;
                if (got !== it.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", it.name, got, it.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; we = 1'b0; wr_addr = 5'd0; din = 32'd0; pc = 32'd0; bd_in = 1'b0;
        exc_code = 5'd0; bad_vaddr_in = 32'd0; hwint = '0; eret = 1'b0;
        cyc(); cyc();
        exp_reg("rst_sr", 5'd12, 32'h0);
        exp_reg("rst_cause", 5'd13, 32'h0);
        exp_reg("rst_epc", 5'd14, 32'h0);
        exp_reg("rst_prid", 5'd15, 32'h12345678);
        exp_reg("rst_count", 5'd9, 32'h0);
        exp_req("rst_req", 1'b0);
        exp_reg("unmapped", 5'd20, 32'h0);
        cyc();
        reset = 1'b1;
        repeat (10) cyc();

        // Hardware interrupt on line 0
        mtc0(5'd12, 32'h0000_0401);
        hwint = 3'b001; pc = 32'h3010; bd_in = 1'b0;
        exp_req("int_req_same_cycle", 1'b1);
        cyc();
        hwint = '0;
        exp_reg("int_sr", 5'd12, 32'h0000_0403);
        exp_reg("int_cause", 5'd13, 32'h0000_0400);
        exp_reg("int_epc", 5'd14, 32'h3010);
        exp_epc("int_epc_port", 32'h3010);
        exp_req("int_req_after", 1'b0);

        // Address error in a delay slot
        mtc0(5'd12, 32'h0);
        exc_code = 5'd4; bad_vaddr_in = 32'h1001; pc = 32'h3024; bd_in = 1'b1;
        exp_req("exc_req", 1'b1);
        cyc();
        exc_code = 5'd0; bd_in = 1'b0;
        exp_reg("exc_epc", 5'd14, 32'h3020);
        exp_epc("exc_epc_port", 32'h3020);
        exp_reg("exc_cause", 5'd13, 32'h8000_0010);
        exp_reg("exc_badvaddr", 5'd8, 32'h1001);
        exp_reg("exc_sr", 5'd12, 32'h2);

        // ERET
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        exp_reg("eret_sr", 5'd12, 32'h0);
        exp_reg("eret_cause", 5'd13, 32'h10);
        exp_epc("eret_epc", 32'h3020);

        // Timer: Compare=3, IM15+IE, then Count=0 (edge E0)
        mtc0(5'd11, 32'd3);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        exp_reg("tmr_count0", 5'd9, 32'd0);
        exp_req("tmr_req0", 1'b0);
        repeat (5) cyc();
        exp_req("tmr_req_e5", 1'b0);
        exp_reg("tmr_cause_e5", 5'd13, 32'h10);
        exp_reg("tmr_count_e5", 5'd9, 32'd2);
        pc = 32'h4000; bd_in = 1'b0;
        cyc();
        exp_req("tmr_req_e6", 1'b1);
        exp_reg("tmr_cause_e6", 5'd13, 32'h4000_8010);
        exp_reg("tmr_count_e6", 5'd9, 32'd3);
        cyc();
        exp_reg("tmr_entry_cause", 5'd13, 32'h4000_8000);
        exp_epc("tmr_entry_epc", 32'h4000);
        exp_reg("tmr_entry_sr", 5'd12, 32'h8003);
        exp_req("tmr_entry_req", 1'b0);

        mtc0(5'd11, 32'h10);
        exp_reg("cmp_clr_cause", 5'd13, 32'h0);
        exp_reg("cmp_val", 5'd11, 32'h10);

        // Interrupt beats a simultaneous exception
        mtc0(5'd12, 32'h0000_0801);
        hwint = 3'b010; exc_code = 5'd10; pc = 32'h5004; bd_in = 1'b0;
        exp_req("prio_req", 1'b1);
        cyc();
        hwint = '0; exc_code = 5'd0;
        exp_reg("prio_cause", 5'd13, 32'h0000_0800);
        exp_epc("prio_epc", 32'h5004);
        exp_reg("prio_sr", 5'd12, 32'h0000_0803);
        exp_reg("prio_badvaddr", 5'd8, 32'h1001);

        // Entry beats a same-cycle MTC0 EPC
        mtc0(5'd12, 32'h0);
        we = 1'b1; wr_addr = 5'd14; din = 32'h5000;
        exc_code = 5'd12; pc = 32'h6008;
        exp_req("epcw_req", 1'b1);
        cyc();
        we = 1'b0; exc_code = 5'd0;
        exp_reg("epcw_epc", 5'd14, 32'h6008);
        exp_epc("epcw_epc_port", 32'h6008);
        exp_reg("epcw_cause", 5'd13, 32'h30);
        exp_reg("epcw_sr", 5'd12, 32'h2);

        // IM write applies during entry; unimplemented IM bits stay 0
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        exp_reg("eret2_sr", 5'd12, 32'h0);
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_FC01;
        exc_code = 5'd8; pc = 32'h7000;
        exp_req("imw_req", 1'b1);
        cyc();
        we = 1'b0; exc_code = 5'd0;
        exp_reg("imw_sr", 5'd12, 32'h0000_9C03);
        exp_reg("imw_cause", 5'd13, 32'h20);
        exp_epc("imw_epc", 32'h7000);

        // Asynchronous reset mid-run with EXL=1 and EPC=0x3008
        mtc0(5'd14, 32'h3008);
        exp_epc("pre_rst_epc", 32'h3008);
        exp_reg("pre_rst_sr", 5'd12, 32'h0000_9C03);
        cyc();
        reset = 1'b0; exc_code = 5'd4;
        exp_reg("mrst_sr", 5'd12, 32'h0);
        exp_reg("mrst_epc", 5'd14, 32'h0);
        exp_epc("mrst_epc_port", 32'h0);
        exp_req("mrst_req", 1'b0);
        exp_reg("mrst_prid", 5'd15, 32'h12345678);
        cyc();
        exp_reg("mrst_cause", 5'd13, 32'h0);
        exp_reg("mrst_count", 5'd9, 32'h0);
        exp_reg("mrst_compare", 5'd11, 32'h0);
        exp_reg("mrst_badvaddr", 5'd8, 32'h0);
        cyc();
        reset = 1'b1; exc_code = 5'd0;
        cyc(); cyc();

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
